// File: rtl/awgn_noise_gen.sv
// awgn_noise_gen
// Two independent pseudo-Gaussian noise streams (I and Q) for the QPSK
// channel model. Each output sample is the exact sum of four signed 18-bit
// uniform values taken from four 32-bit Fibonacci LFSRs. This relies on the
// central-limit theorem to approximate a Gaussian.
//
// Output handshake: noise_valid is a plain valid with no ready. While
// noise_valid is high, every edge with en=1 replaces I_noise/Q_noise with a
// new sample. The consumer must take the sample in that cycle. While en=0,
// all outputs hold their values.
//
// Datapath:
//   LFSR state (registered) -> u_k = lfsr_k[17:0] (signed)
//   stage B: pairwise sums, 19-bit signed, exact
//   stage C: final sums, 20-bit signed, exact -> I_noise / Q_noise
// Each enabled cycle, every LFSR leaps LEAP=18 steps. Each uniform sample
// therefore uses only fresh bits.

module awgn_noise_gen #(
    parameter logic [31:0] SEED = 32'h1D872B41
) (
    input  logic        clk_fs,
    input  logic        rst,
    input  logic        en,
    input  logic        seed_load,
    input  logic [31:0] seed_in,
    output logic [19:0] I_noise,
    output logic [19:0] Q_noise,
    output logic        noise_valid
);

    // LFSR steps per enabled clock; equals the uniform sample width so that
    // consecutive samples share no bits.
    localparam int LEAP = 18;

    // Odd 32-bit constant (golden ratio) used to decorrelate the eight seeds.
    localparam logic [31:0] SEED_SPREAD = 32'h9E3779B9;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // One Fibonacci step, polynomial x^32 + x^22 + x^2 + x + 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic nb;
        nb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], nb};
    endfunction

    // LEAP unrolled steps; synthesises to a pure XOR network.
    function automatic logic [31:0] lfsr_leap(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < LEAP; i++) begin
            r = lfsr_step(r);
        end
        return r;
    endfunction

    // Derive the seed of LFSR k from a base seed. The all-zero state would
    // lock the LFSR, so a zero result is replaced with 1.
    function automatic logic [31:0] seed_mix(input logic [31:0] base,
                                             input logic [2:0]  k);
        logic [31:0] m;
        m = base ^ ({29'd0, k} * SEED_SPREAD);
        if (m == 32'd0) begin
            m = 32'h0000_0001;
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    logic [31:0]        lfsr_q [8];
    logic [31:0]        lfsr_d [8];
    logic [31:0]        rst_seed [8];
    logic signed [17:0] u [8];

    // Stage B: pairwise sums
    logic signed [18:0] pi0_q, pi1_q, pq0_q, pq1_q;
    logic signed [18:0] pi0_d, pi1_d, pq0_d, pq1_d;
    logic               vb_q, vb_d;

    // Stage C: output registers
    logic signed [19:0] i_noise_q, q_noise_q;
    logic signed [19:0] i_noise_d, q_noise_d;
    logic               valid_q, valid_d;

    // ------------------------------------------------------------------
    // Combinational logic
    // ------------------------------------------------------------------

    // Power-on seeds, derived from the SEED parameter (constant after elaboration).
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            rst_seed[k] = seed_mix(SEED, k[2:0]);
        end
    end

    // Uniform samples from the registered LFSR state, read as two's complement.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            u[k] = signed'(lfsr_q[k][17:0]);
        end
    end

    // LFSR next state: seed_load reseeds the LFSRs even when en=0; otherwise en leaps them by LEAP steps.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            lfsr_d[k] = lfsr_q[k];
            if (seed_load) begin
                lfsr_d[k] = seed_mix(seed_in, k[2:0]);
            end else if (en) begin
                lfsr_d[k] = lfsr_leap(lfsr_q[k]);
            end
        end
    end

    // Pipeline next state: seed_load flushes to zero; en advances both stages.
    always_comb begin
        pi0_d     = pi0_q;
        pi1_d     = pi1_q;
        pq0_d     = pq0_q;
        pq1_d     = pq1_q;
        vb_d      = vb_q;
        i_noise_d = i_noise_q;
        q_noise_d = q_noise_q;
        valid_d   = valid_q;

        if (seed_load) begin
            pi0_d     = '0;
            pi1_d     = '0;
            pq0_d     = '0;
            pq1_d     = '0;
            vb_d      = 1'b0;
            i_noise_d = '0;
            q_noise_d = '0;
            valid_d   = 1'b0;
        end else if (en) begin
            // Sign-extend before adding, so each sum is exact in 19 bits.
            pi0_d = {u[0][17], u[0]} + {u[1][17], u[1]};
            pi1_d = {u[2][17], u[2]} + {u[3][17], u[3]};
            pq0_d = {u[4][17], u[4]} + {u[5][17], u[5]};
            pq1_d = {u[6][17], u[6]} + {u[7][17], u[7]};
            vb_d  = 1'b1;

            // The range is [-2^19, 2^19-4], so the result fits in 20 bits and never saturates.
            i_noise_d = {pi0_q[18], pi0_q} + {pi1_q[18], pi1_q};
            q_noise_d = {pq0_q[18], pq0_q} + {pq1_q[18], pq1_q};
            valid_d   = vb_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // LFSR state register; rst returns every generator to its power-on seed.
    always_ff @(posedge clk_fs) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                lfsr_q[k] <= rst_seed[k];
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                lfsr_q[k] <= lfsr_d[k];
            end
        end
    end

    // Pipeline registers; rst clears all partial data and both valid flags.
    always_ff @(posedge clk_fs) begin
        if (rst) begin
            pi0_q     <= '0;
            pi1_q     <= '0;
            pq0_q     <= '0;
            pq1_q     <= '0;
            vb_q      <= 1'b0;
            i_noise_q <= '0;
            q_noise_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            pi0_q     <= pi0_d;
            pi1_q     <= pi1_d;
            pq0_q     <= pq0_d;
            pq1_q     <= pq1_d;
            vb_q      <= vb_d;
            i_noise_q <= i_noise_d;
            q_noise_q <= q_noise_d;
            valid_q   <= valid_d;
        end
    end

    assign I_noise     = i_noise_q;
    assign Q_noise     = q_noise_q;
    assign noise_valid = valid_q;

endmodule

// File: tb/tb_awgn_noise_gen.sv
// tb_awgn_noise_gen
// Directed bench for awgn_noise_gen. A bit-serial LFSR reference produces
// the expected sample stream, which is queued in exp_q. Hand-computed first
// samples for known seeds anchor the reference to absolute values.

module tb_awgn_noise_gen;

  localparam logic [31:0] SEED = 32'h1D872B41;

  // ---------------- clock / reset ----------------
  logic        clk_fs = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        seed_load = 1'b0;
  logic [31:0] seed_in = '0;
  logic [19:0] I_noise;
  logic [19:0] Q_noise;
  logic        noise_valid;

  always #50 clk_fs = ~clk_fs;

  awgn_noise_gen #(.SEED(SEED)) dut (
    .clk_fs      (clk_fs),
    .rst         (rst),
    .en          (en),
    .seed_load   (seed_load),
    .seed_in     (seed_in),
    .I_noise     (I_noise),
    .Q_noise     (Q_noise),
    .noise_valid (noise_valid)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [39:0] exp_q[$];
  logic [39:0] last_exp = '0;
  int          n_en = 0;
  logic [31:0] m [8];

  task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_seed(input logic [31:0] base);
    for (int k = 0; k < 8; k++) begin
      logic [31:0] t;
      t = base ^ (32'(k) * 32'h9E3779B9);
      m[k] = (t == 32'd0) ? 32'h1 : t;
    end
  endtask

  task automatic model_advance();
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 18; s++) begin
        logic fb;
        fb = m[k][31] ^ m[k][21] ^ m[k][1] ^ m[k][0];
        m[k] = {m[k][30:0], fb};
      end
    end
  endtask

  function automatic logic [39:0] model_sample();
    int si;
    int sq;
    si = 0;
    sq = 0;
    for (int k = 0; k < 8; k++) begin
      int v;
      v = int'(m[k][17:0]);
      if (v >= 131072) v = v - 262144;
      if (k < 4) si = si + v;
      else sq = sq + v;
    end
    return {si[19:0], sq[19:0]};
  endfunction

  // ---------------- driver ----------------
  // Applies one cycle of inputs, advances the reference model the same way, then checks the outputs 1 time unit after the edge.
  task automatic tick(input logic r, input logic e, input logic sl, input logic [31:0] si);
    int iv;
    rst = r;
    en = e;
    seed_load = sl;
    seed_in = si;
    @(posedge clk_fs);
    #1;
    if (r) begin
      model_seed(SEED);
      exp_q.delete();
      n_en = 0;
      last_exp = '0;
    end else if (sl) begin
      model_seed(si);
      exp_q.delete();
      n_en = 0;
      last_exp = '0;
    end else if (e) begin
      exp_q.push_back(model_sample());
      model_advance();
      n_en++;
      if (n_en >= 2) last_exp = exp_q.pop_front();
    end
    check_eq("valid", {39'd0, noise_valid}, {39'd0, (n_en >= 2)});
    check_eq("iq", {I_noise, Q_noise}, last_exp);
    if (noise_valid) begin
      iv = int'(signed'(I_noise));
      check_eq("range_i", {39'd0, (iv >= -524288 && iv <= 524284)}, 40'd1);
    end
  endtask

  task automatic check_abs(input string tag, input int ei, input int eq);
    logic [19:0] a;
    logic [19:0] b;
    a = ei[19:0];
    b = eq[19:0];
    check_eq(tag, {I_noise, Q_noise}, {a, b});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held 3 cycles with en=1
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 32'd0);

    // Fill latency: valid on the 2nd enabled edge, first sample hand-computed
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    check_abs("first_sample_default", 171222, -226842);

    // Continuous stream
    for (int i = 0; i < 300; i++) tick(1'b0, 1'b1, 1'b0, 32'd0);

    // en gating, roughly 50%
    for (int i = 0; i < 400; i++) tick(1'b0, 1'(($urandom_range(0, 1))), 1'b0, 32'd0);

    // Reseed with en=1, then run
    tick(1'b0, 1'b1, 1'b1, 32'hCAFEF00D);
    for (int i = 0; i < 150; i++) tick(1'b0, 1'b1, 1'b0, 32'd0);

    // Reseed while en=0 still takes effect
    tick(1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
    for (int i = 0; i < 60; i++) tick(1'b0, 1'(($urandom_range(0, 1))), 1'b0, 32'd0);

    // Zero seed: LFSR0 becomes 1; first sample hand-computed
    tick(1'b0, 1'b1, 1'b1, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    check_abs("first_sample_zero_seed", -206249, 292326);
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b1, 1'b0, 32'd0);

    // Mid-run rst together with seed_load and en: rst wins
    tick(1'b1, 1'b1, 1'b1, 32'hCAFEF00D);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    check_abs("after_rst_over_seed_load", 171222, -226842);
    for (int i = 0; i < 50; i++) tick(1'b0, 1'b1, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
